// File: rtl/uart_pkg.sv
// Shared UART TX definitions: parity encodings, serialiser states and line idle level.
// Header only; no logic.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: registered level, head word visible combinationally on rdata.
// Push ignored when full (even with a same-cycle pop); pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, LSB-first, runtime baud divisor, fixed frame format.
// First start bit one cycle after accept into idle; tx_ready = !full, frames run back-to-back.
module uart_tx_fifo import uart_pkg::*; #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [3:0]           LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]           LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [DIV_WIDTH-1:0] CNT_ONE   = DIV_WIDTH'(1);

  tx_state_t            state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [DIV_WIDTH-1:0] div_q, div_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [3:0]           bit_cnt, bit_n;
  logic                 par_acc, par_n;
  logic                 tx_q, tx_n;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 start_frame;
  logic                 bit_end;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign tx_ready    = !fifo_full;
  assign busy        = (state != IDLE) || (fifo_level != '0);
  assign uart_tx     = tx_q;
  assign start_frame = !fifo_empty && enable;
  assign bit_end     = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      par_acc <= 1'b0;
      tx_q    <= IDLE_LEVEL;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div_q   <= div_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_n;
      par_acc <= par_n;
      tx_q    <= tx_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    div_n    = div_q;
    shreg_n  = shreg;
    bit_n    = bit_cnt;
    par_n    = par_acc;
    tx_n     = tx_q;
    fifo_pop = 1'b0;

    case (state)
      IDLE: begin
        if (start_frame) begin
          fifo_pop = 1'b1;
          shreg_n  = fifo_head;
          div_n    = baud_div;
          cnt_n    = baud_div;
          tx_n     = 1'b0;
          state_n  = START;
        end
      end

      START: begin
        if (bit_end) begin
          state_n = DATA;
          tx_n    = shreg[0];
          par_n   = shreg[0];
          shreg_n = shreg >> 1;
          bit_n   = '0;
          cnt_n   = div_q;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_n = div_q;
          if (bit_cnt == LAST_DATA) begin
            bit_n = '0;
            if (PARITY != PAR_NONE) begin
              state_n = PAR;
              tx_n    = (PARITY == PAR_ODD) ? ~par_acc : par_acc;
            end else begin
              state_n = STOP;
              tx_n    = IDLE_LEVEL;
            end
          end else begin
            bit_n   = bit_cnt + 4'd1;
            tx_n    = shreg[0];
            par_n   = par_acc ^ shreg[0];
            shreg_n = shreg >> 1;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end

      PAR: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = IDLE_LEVEL;
          bit_n   = '0;
          cnt_n   = div_q;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end

      STOP: begin
        if (bit_end) begin
          if (bit_cnt == LAST_STOP) begin
            // Chain straight into the next start bit so queued words leave no idle gap.
            if (start_frame) begin
              fifo_pop = 1'b1;
              shreg_n  = fifo_head;
              div_n    = baud_div;
              cnt_n    = baud_div;
              tx_n     = 1'b0;
              state_n  = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_n = bit_cnt + 4'd1;
            cnt_n = div_q;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end

      default: begin
        state_n = IDLE;
        tx_n    = IDLE_LEVEL;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: default 8N1 instance plus a 7-bit odd-parity 2-stop instance.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, enable_b;
  logic [15:0] baud_div, baud_div_b;
  logic        tx_valid, tx_valid_b;
  logic [7:0]  tx_data;
  logic [6:0]  tx_data_b;
  logic        tx_ready, tx_ready_b;
  logic        uart_tx, uart_tx_b;
  logic        busy, busy_b;
  logic [3:0]  fifo_level, fifo_level_b;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  logic       exp_bits[$];

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .baud_div(baud_div),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .uart_tx(uart_tx), .busy(busy), .fifo_level(fifo_level)
  );

  uart_tx_fifo #(.DATA_BITS(7), .FIFO_DEPTH(8), .DIV_WIDTH(16), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .baud_div(baud_div_b),
    .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b),
    .uart_tx(uart_tx_b), .busy(busy_b), .fifo_level(fifo_level_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Handshake one word into the default instance and record it on the scoreboard.
  task automatic push_word(input logic [7:0] w);
    int n = 0;
    tx_valid = 1'b1;
    tx_data  = w;
    while (tx_ready !== 1'b1 && n < 5000) begin cyc(); n++; end
    cyc();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    exp_q.push_back(w);
  endtask

  // Wait for a start bit, then capture 10 bit periods; stable=0 if any bit wobbles within its period.
  task automatic rx_frame(input int div, output logic [9:0] bits, output bit stable, output int waited);
    waited = 0;
    while (uart_tx !== 1'b0 && waited < 3000) begin cyc(); waited++; end
    stable = 1'b1;
    for (int b = 0; b < 10; b++) begin
      bits[b] = uart_tx;
      for (int c = 0; c <= div; c++) begin
        if (uart_tx !== bits[b]) stable = 1'b0;
        cyc();
      end
    end
  endtask

  function automatic logic [7:0] next_exp();
    return (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; enable_b = 1'b0;
    baud_div = 16'd3; baud_div_b = 16'd0;
    tx_valid = 1'b0; tx_valid_b = 1'b0; tx_data = 8'h00; tx_data_b = 7'h00;
    #23;
    tests_run++; if (uart_tx !== 1'b1)  begin tests_failed++; $display("FAIL reset_uart_tx: got %b exp 1", uart_tx); end
    tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_ready: got %b exp 1", tx_ready); end
    tests_run++; if (busy !== 1'b0)     begin tests_failed++; $display("FAIL reset_busy: got %b exp 0", busy); end
    tests_run++; if (fifo_level !== 4'd0) begin tests_failed++; $display("FAIL reset_level: got %0d exp 0", fifo_level); end
    tests_run++; if (uart_tx_b !== 1'b1) begin tests_failed++; $display("FAIL reset_uart_tx_b: got %b exp 1", uart_tx_b); end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic_frame();
    logic [9:0] bits; bit stable; int waited; logic [7:0] e;
    enable = 1'b1; baud_div = 16'd3;
    push_word(8'hA5);
    tests_run++; if (uart_tx !== 1'b1) begin tests_failed++; $display("FAIL basic_early_start: got %b exp 1", uart_tx); end
    rx_frame(3, bits, stable, waited);
    e = next_exp();
    tests_run++; if (waited !== 1) begin tests_failed++; $display("FAIL basic_latency: got %0d exp 1", waited); end
    tests_run++; if (bits !== {1'b1, e, 1'b0} || !stable) begin tests_failed++; $display("FAIL basic_frame: got %b stable=%0d exp %b", bits, stable, {1'b1, e, 1'b0}); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_end: got %b exp 0", busy); end
    tests_run++; if (fifo_level !== 4'd0) begin tests_failed++; $display("FAIL basic_level_end: got %0d exp 0", fifo_level); end
  endtask

  task automatic test_parity_frame();
    logic [6:0] w; logic e; int bad;
    w = 7'h41; bad = 0;
    enable_b = 1'b1; baud_div_b = 16'd0;
    tx_valid_b = 1'b1; tx_data_b = w;
    cyc();
    tx_valid_b = 1'b0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 7; i++) exp_bits.push_back(w[i]);
    exp_bits.push_back(~(^w));
    exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b1);
    tests_run++; if (uart_tx_b !== 1'b1) begin tests_failed++; $display("FAIL parity_early_start: got %b exp 1", uart_tx_b); end
    cyc();
    for (int i = 0; i < 11; i++) begin
      e = exp_bits.pop_front();
      tests_run++; if (uart_tx_b !== e) begin tests_failed++; $display("FAIL parity_bit%0d: got %b exp %b", i, uart_tx_b, e); end
      cyc();
    end
    tests_run++; if (busy_b !== 1'b0 || uart_tx_b !== 1'b1) begin tests_failed++; $display("FAIL parity_frame_len: busy=%b line=%b exp busy=0 line=1", busy_b, uart_tx_b); end
    enable_b = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits; bit stable; int waited; logic [7:0] e; logic [7:0] w9;
    enable = 1'b0; baud_div = 16'd1;
    for (int i = 0; i < 8; i++) begin
      tx_valid = 1'b1; tx_data = 8'($urandom);
      cyc();
      exp_q.push_back(tx_data);
    end
    w9 = 8'h9C; tx_data = w9;
    tests_run++; if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_full_ready: got %b exp 0", tx_ready); end
    tests_run++; if (fifo_level !== 4'd8) begin tests_failed++; $display("FAIL b2b_full_level: got %0d exp 8", fifo_level); end
    repeat (3) cyc();
    tests_run++; if (fifo_level !== 4'd8 || uart_tx !== 1'b1) begin tests_failed++; $display("FAIL b2b_held: level=%0d line=%b exp 8 1", fifo_level, uart_tx); end
    fork
      begin
        enable = 1'b1;
        cyc();
        tests_run++; if (fifo_level !== 4'd7 || tx_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_pop: level=%0d ready=%b exp 7 1", fifo_level, tx_ready); end
        cyc();
        tx_valid = 1'b0;
        exp_q.push_back(w9);
        tests_run++; if (fifo_level !== 4'd8) begin tests_failed++; $display("FAIL b2b_ninth_accept: level=%0d exp 8", fifo_level); end
      end
      begin
        for (int k = 0; k < 9; k++) begin
          rx_frame(1, bits, stable, waited);
          e = next_exp();
          tests_run++; if (waited !== (k == 0 ? 1 : 0)) begin tests_failed++; $display("FAIL b2b_gap%0d: got %0d exp %0d", k, waited, (k == 0 ? 1 : 0)); end
          tests_run++; if (bits !== {1'b1, e, 1'b0} || !stable) begin tests_failed++; $display("FAIL b2b_frame%0d: got %b exp %b", k, bits, {1'b1, e, 1'b0}); end
        end
      end
    join
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy_end: got %b exp 0", busy); end
  endtask

  task automatic test_enable_drop();
    logic [9:0] bits; bit stable; int waited; logic [7:0] e; bit hi;
    enable = 1'b1; baud_div = 16'd3;
    fork
      begin
        push_word(8'h3A); push_word(8'hC5); push_word(8'h0F);
        repeat (8) cyc();
        enable = 1'b0;
      end
      begin
        rx_frame(3, bits, stable, waited);
        e = next_exp();
        tests_run++; if (bits !== {1'b1, e, 1'b0} || !stable) begin tests_failed++; $display("FAIL drop_frame1: got %b exp %b", bits, {1'b1, e, 1'b0}); end
      end
    join
    tests_run++; if (fifo_level !== 4'd2 || busy !== 1'b1) begin tests_failed++; $display("FAIL drop_after: level=%0d busy=%b exp 2 1", fifo_level, busy); end
    hi = 1'b1;
    repeat (20) begin if (uart_tx !== 1'b1) hi = 1'b0; cyc(); end
    tests_run++; if (!hi || fifo_level !== 4'd2) begin tests_failed++; $display("FAIL drop_idle: high=%0d level=%0d exp 1 2", hi, fifo_level); end
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rx_frame(3, bits, stable, waited);
      e = next_exp();
      tests_run++; if (waited !== (k == 0 ? 1 : 0)) begin tests_failed++; $display("FAIL drop_resume_gap%0d: got %0d exp %0d", k, waited, (k == 0 ? 1 : 0)); end
      tests_run++; if (bits !== {1'b1, e, 1'b0} || !stable) begin tests_failed++; $display("FAIL drop_resume%0d: got %b exp %b", k, bits, {1'b1, e, 1'b0}); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits; bit stable; int waited; logic [7:0] e;
    enable = 1'b1; baud_div = 16'd3;
    push_word(8'h00); push_word(8'hFF);
    repeat (6) cyc();
    tests_run++; if (uart_tx !== 1'b0) begin tests_failed++; $display("FAIL rst_pre_low: got %b exp 0", uart_tx); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (uart_tx !== 1'b1) begin tests_failed++; $display("FAIL rst_async_line: got %b exp 1", uart_tx); end
    tests_run++; if (fifo_level !== 4'd0 || tx_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_async_state: level=%0d ready=%b busy=%b exp 0 1 0", fifo_level, tx_ready, busy); end
    exp_q.delete();
    cyc();
    rst_n = 1'b1;
    cyc();
    push_word(8'h3C);
    rx_frame(3, bits, stable, waited);
    e = next_exp();
    tests_run++; if (waited !== 1 || bits !== {1'b1, e, 1'b0} || !stable) begin tests_failed++; $display("FAIL rst_recover: got %b wait=%0d exp %b wait=1", bits, waited, {1'b1, e, 1'b0}); end
  endtask

  task automatic test_baud_change();
    logic [9:0] bits; bit stable; int waited; logic [7:0] e;
    enable = 1'b1; baud_div = 16'd3;
    fork
      begin
        push_word(8'h55); push_word(8'h96);
        repeat (10) cyc();
        baud_div = 16'd7;
      end
      begin
        rx_frame(3, bits, stable, waited);
        e = next_exp();
        tests_run++; if (bits !== {1'b1, e, 1'b0} || !stable) begin tests_failed++; $display("FAIL baud_old_frame: got %b stable=%0d exp %b", bits, stable, {1'b1, e, 1'b0}); end
        rx_frame(7, bits, stable, waited);
        e = next_exp();
        tests_run++; if (waited !== 0 || bits !== {1'b1, e, 1'b0} || !stable) begin tests_failed++; $display("FAIL baud_new_frame: got %b stable=%0d wait=%0d exp %b", bits, stable, waited, {1'b1, e, 1'b0}); end
      end
    join
    tests_run++; if (busy !== 1'b0 || uart_tx !== 1'b1) begin tests_failed++; $display("FAIL baud_end: busy=%b line=%b exp 0 1", busy, uart_tx); end
    baud_div = 16'd3;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity_frame();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();
    test_baud_change();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised, buffered UART transmitter; successor to the fixed single-line TX path that the core drives onto io_out[0].
- Accepts words over a valid/ready handshake into an internal FIFO.
- Serialises them LSB-first with a runtime baud divisor and compile-time frame format (data bits, parity, stop bits).
- Sits between the core/Wishbone side and the user I/O pad; one instance per TX channel.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9
FIFO_DEPTH, 8, FIFO entries; power of 2, >= 2
DIV_WIDTH, 16, width of baud divisor input
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; 1 or 2

Ports:
clk  in  1  single system clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  1 = start new frames; 0 = finish current frame, then hold idle
baud_div  in  DIV_WIDTH  bit period = baud_div+1 clk cycles
tx_valid  in  1  producer has a word
tx_data  in  DATA_BITS  word to send
tx_ready  out  1  FIFO can accept; = !full
uart_tx  out  1  serial line, idle high, registered
busy  out  1  frame in progress or FIFO non-empty
fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered

Behaviour:
- Reset (async assert, sync deassert by upstream): uart_tx=1, tx_ready=1, busy=0, fifo_level=0, FSM=IDLE, FIFO emptied. Reset mid-frame aborts the frame immediately; the line goes high with no glitch low.
- Handshake: a word is written on a rising edge with tx_valid && tx_ready.
  - tx_ready derives only from registered state (!full), never from tx_valid.
  - When full, a simultaneous pop does not allow a push in that cycle.
  - tx_data is ignored when not accepted.
  - tx_valid may drop without acceptance; no protocol error.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: leave when FIFO non-empty and enable=1. Pop the head into the shift register, latch baud_div into the divisor register, uart_tx<=0, go to START.
  - START: uart_tx=0 for one bit period, then DATA.
  - DATA: DATA_BITS periods, LSB first. Then PAR if PARITY!=0, else STOP.
  - PAR: one period. Even parity: XOR of the data bits. Odd parity: its inverse.
  - STOP: uart_tx=1 for STOP_BITS periods. At the end, if FIFO non-empty and enable=1, go directly to START (no idle gap); else IDLE.
- Bit timing:
  - Down-counter reloads with the latched divisor at each bit boundary, so every bit is exactly baud_div+1 cycles.
  - baud_div=0 gives 1 cycle per bit.
  - A baud_div change mid-frame takes effect only at the next frame's start.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * (baud_div+1) cycles.
- Latency: a word accepted at edge N into an empty FIFO with the FSM in IDLE and enable=1 gives uart_tx=0 after edge N+1.
- Deasserting enable mid-frame completes the current frame including stop bits. No pop occurs while enable=0.
- fifo_level: +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- busy = (FSM != IDLE) || (fifo_level != 0).
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are resolved with an extra pointer bit.
- All outputs are registered except tx_ready and busy, which decode registered state only.

Decomposition:
- Package uart_pkg holds:
  - parity encoding constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - FSM state enum;
  - IDLE_LEVEL=1'b1.
- Sub-module sync_fifo (parametrised WIDTH, DEPTH; push/pop/full/empty/level) is instantiated once. The serialiser FSM and baud counter stay in the top module.

Test Plan:
1. Defaults, baud_div=3, push 0xA5 → uart_tx falls one edge after accept. Line sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1. Total 40 cycles, then busy=0.
2. PARITY=2, DATA_BITS=7, STOP_BITS=2, baud_div=0, push 0x41 → bits 0, 1000001, parity 1, 1,1. Frame = 11 cycles.
3. Push 9 words back-to-back with FIFO_DEPTH=8 and enable=0 → tx_ready=0 after 8 accepts, fifo_level=8, 9th word held. Set enable=1 → 9th accepted one cycle after the first pop. All 9 frames are contiguous with no idle cycle between stop and start.
4. enable dropped mid-DATA of frame 1 with 2 words queued → frame 1 completes, line idles high, fifo_level=2. Re-enable → frames resume in order.
5. rst_n asserted during DATA → uart_tx=1 asynchronously, fifo_level=0, tx_ready=1. After release, a new push 0x3C transmits correctly.
6. Change baud_div 3→7 mid-frame → current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
